halfband_decimator: RTL and testbench
=====================================

# halfband_decimator

Parametrised halfband FIR with 2:1 decimation for the real-sample receive path. It accepts one signed sample per valid cycle, filters with a symmetric halfband kernel, and emits one rounded, saturated output for every second valid input. A runtime bypass mode provides the legacy 1-cycle register pass-through. There is no backpressure: the upstream is valid-only and the downstream always accepts.

## Interface
- WIDTH, 16, signed sample width for input and output
- COEF_WIDTH, 16, signed coefficient width, format Q1.(COEF_WIDTH-1)
- NUM_TAPS, 11, filter length; must satisfy NUM_TAPS % 4 == 3; K = (NUM_TAPS+1)/4
- COEFS, 48'h2640_F894_012C, K packed non-zero side coefficients; COEFS[j] = bits [j*COEF_WIDTH +: COEF_WIDTH]; default = {9792, -1900, 300}
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_bypass  in  1  1 = pass-through mode, 0 = filter/decimate mode
- i_in_data  in  WIDTH  signed input sample
- i_in_valid  in  1  input sample qualifier; may be high every cycle
- o_out_data  out  WIDTH  signed output sample
- o_out_valid  out  1  output qualifier; single-cycle pulse per output

## Operation
- Delay line d[0..NUM_TAPS-1], with d[0] newest. It shifts only on i_in_valid in filter mode.
- Phase bit toggles on each accepted input. An output is produced when the input that sets phase 0→1 has been accepted, i.e. on the 2nd, 4th, 6th… valid input after reset or flush.
- Centre index M = (NUM_TAPS-1)/2. The centre coefficient is fixed at 2^(COEF_WIDTH-2) (0.5). Odd-index taps other than M are zero.
- Output sum: y = 0.5·d[M] + Σ_{j=0..K-1} COEFS[j]·(d[2j] + d[NUM_TAPS-1-2j]).
- Width rules:
  - pre-add is WIDTH+1 bits
  - products are WIDTH+COEF_WIDTH+1 bits
  - accumulator adds ceil(log2(K+1)) guard bits
  - no intermediate truncation
- Output scaling:
  - add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1 (round-half-up)
  - saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
- Startup: history after reset or flush is zero. No warm-up suppression; early outputs are produced normally.
- Bypass mode:
  - o_out_data <= i_in_data and o_out_valid <= i_in_valid every cycle
  - delay line and phase are held at zero
- Mode change: any cycle where i_bypass differs from its registered previous value causes a flush:
  - delay line cleared and phase cleared to 0
  - all in-flight pipeline valids killed; no stale filter output is ever emitted
  - the input sampled in that cycle is handled in the new mode

## Timing
- Reset (i_reset high at a clock edge) clears the following:
  - o_out_data = 0 and o_out_valid = 0
  - delay line = 0 and phase = 0
  - all pipeline valid bits = 0
  - previous-bypass register = current i_bypass
- Filter latency: 4 clocks. An input sampled at edge N that completes a pair produces o_out_valid = 1 registered at edge N+4. Pipeline stages are pre-add, multiply, sum, then round/saturate.
- Bypass latency: 1 clock.
- Throughput: at most one output per two valid inputs. Arbitrary gaps in i_in_valid are legal, and the phase count ignores invalid cycles.
- Reset mid-stream discards all in-flight outputs. The first valid after reset is phase 0.
- o_out_data holds its last value while o_out_valid is low.

## Test plan
- Odd-aligned impulse (defaults): inputs 0, 16384, then zeros, all valid, back-to-back. Required outputs: 150, -950, 4896, 4896, -950, 150, then 0. Each appears 4 clocks after its completing input.
- Even-aligned impulse: inputs 16384, then zeros. Required outputs: 0, 0, 8192, 0, 0, 0.
- Rounding: input 1 at centre-only alignment (even-aligned impulse) → 1 (0.5 rounds up). Input -1 at the same alignment → 0.
- Saturation, DC gain and gaps:
  - instance with COEFS = 48'h4000_4000_4000
  - DC +20000 → settles at 32767; DC -20000 → settles at -32768
  - default instance, DC 100 with random i_in_valid gaps → settles at 100
- Bypass and flush: with i_bypass=1, inputs 5, 6, 7 on consecutive cycles → the same values with valid 1 cycle later. Then:
  - assert i_bypass during an in-flight filter output → that output is never emitted
  - deassert i_bypass, then feed DC 100 → first output appears on the 2nd valid, and output settles at 100 by the 6th output
- Reset mid-operation: assert i_reset for 1 cycle 2 clocks after a pair completes. Required response:
  - no o_out_valid for that pair
  - outputs read 0 during reset
  - the next pair completes on the 2nd valid after reset

Source files
------------

// File: rtl/halfband_decimator.sv
`default_nettype none
// ============================================================================
// Module   : halfband_decimator
// Brief    : Symmetric halfband FIR, 2:1 decimation, runtime register bypass.
// Revision : 1.0 - initial release
// ============================================================================
module halfband_decimator #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 11,
    parameter logic [((NUM_TAPS + 1) / 4) * COEF_WIDTH - 1:0] COEFS = 48'h2640_F894_012C
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_bypass,
    input  logic signed [WIDTH-1:0] i_in_data,
    input  logic                    i_in_valid,
    output logic signed [WIDTH-1:0] o_out_data,
    output logic                    o_out_valid
);

    localparam int c_K   = (NUM_TAPS + 1) / 4;
    localparam int c_M   = (NUM_TAPS - 1) / 2;
    localparam int c_PAW = WIDTH + 1;
    localparam int c_PW  = WIDTH + COEF_WIDTH + 1;
    localparam int c_AW  = c_PW + $clog2(c_K + 1);

    localparam logic signed [c_AW-1:0] c_HALF    = c_AW'(1) <<< (COEF_WIDTH - 2);
    localparam logic signed [c_AW-1:0] c_SAT_HI  = {{(c_AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_SAT_LO  = {{(c_AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic                         r_prev_bypass;
    logic                         r_phase;
    logic signed [WIDTH-1:0]      r_dly  [NUM_TAPS];
    logic signed [c_PAW-1:0]      r_pre  [c_K];
    logic signed [WIDTH-1:0]      r_ctr;
    logic signed [c_PW-1:0]       r_prod [c_K+1];
    logic signed [c_AW-1:0]       r_acc;
    logic [3:0]                   r_vld;

    logic signed [COEF_WIDTH-1:0] w_coef [c_K];
    logic                         w_flush;
    logic                         w_kill;
    logic                         w_pair;
    logic signed [c_AW-1:0]       w_sum;
    logic signed [c_AW-1:0]       w_rnd;
    logic signed [c_AW-1:0]       w_shr;
    logic signed [WIDTH-1:0]      w_sat;

    assign w_flush = i_bypass != r_prev_bypass;
    assign w_kill  = i_bypass | w_flush;
    // A flush resets the phase, so the input sampled with it can never close a pair.
    assign w_pair  = i_in_valid & ~i_bypass & ~w_flush & r_phase;

    always_comb begin
        for (int j = 0; j < c_K; j++) begin
            w_coef[j] = COEFS[j*COEF_WIDTH +: COEF_WIDTH];
        end
    end

    always_ff @(posedge i_clock) begin
        r_prev_bypass <= i_bypass;
        if (i_reset || i_bypass) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_dly[i] <= '0;
            end
            r_phase <= 1'b0;
        end else if (w_flush || i_in_valid) begin
            r_dly[0] <= i_in_valid ? i_in_data : '0;
            for (int i = 1; i < NUM_TAPS; i++) begin
                r_dly[i] <= w_flush ? '0 : r_dly[i-1];
            end
            r_phase <= i_in_valid & ~(r_phase & ~w_flush);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || w_kill) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[2:0], w_pair};
        end
    end

    // Pre-add, multiply and sum registers carry no reset; r_vld qualifies them.
    always_ff @(posedge i_clock) begin
        for (int j = 0; j < c_K; j++) begin
            r_pre[j]  <= c_PAW'(r_dly[2*j]) + c_PAW'(r_dly[NUM_TAPS-1-2*j]);
            r_prod[j] <= c_PW'(r_pre[j]) * c_PW'(w_coef[j]);
        end
        r_ctr        <= r_dly[c_M];
        r_prod[c_K]  <= c_PW'(r_ctr) <<< (COEF_WIDTH - 2);
        r_acc        <= w_sum;
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j <= c_K; j++) begin
            w_sum = w_sum + c_AW'(r_prod[j]);
        end
    end

    assign w_rnd = r_acc + c_HALF;
    assign w_shr = w_rnd >>> (COEF_WIDTH - 1);

    always_comb begin
        w_sat = w_shr[WIDTH-1:0];
        if (w_shr > c_SAT_HI) begin
            w_sat = c_SAT_HI[WIDTH-1:0];
        end else if (w_shr < c_SAT_LO) begin
            w_sat = c_SAT_LO[WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
        end else if (i_bypass) begin
            o_out_data  <= i_in_data;
            o_out_valid <= i_in_valid;
        end else begin
            o_out_valid <= r_vld[3] & ~w_flush;
            if (r_vld[3] && !w_flush) begin
                o_out_data <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_halfband_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_halfband_decimator
// Brief    : Randomised and directed bench for halfband_decimator, two instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_halfband_decimator;

    localparam int W  = 16;
    localparam int CW = 16;
    localparam int N  = 11;
    localparam int K  = 3;
    localparam int M  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                byp;
    logic                vld;
    logic signed [W-1:0] din;
    logic signed [W-1:0] out0, out1;
    logic                ov0, ov1;

    halfband_decimator u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_bypass(byp), .i_in_data(din),
        .i_in_valid(vld), .o_out_data(out0), .o_out_valid(ov0)
    );

    halfband_decimator #(.COEFS(48'h4000_4000_4000)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_bypass(byp), .i_in_data(din),
        .i_in_valid(vld), .o_out_data(out1), .o_out_valid(ov1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference state per instance: history, phase, scheduled outputs, expected pins
    int  coef  [2][K];
    int  hist  [2][N];
    bit  ph    [2];
    bit  prevb [2];
    bit  sv    [2][8];
    int  sd    [2][8];
    bit  ev    [2];
    int  ed    [2];
    int  got0[$];
    int  expq[$];
    int  last0, last1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int ref_y(input int k);
        longint acc;
        acc = longint'(hist[k][M]) * (longint'(1) << (CW - 2));
        for (int j = 0; j < K; j++) begin
            acc += longint'(coef[k][j]) * longint'(hist[k][2*j] + hist[k][N-1-2*j]);
        end
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic clear_state(input int k);
        for (int i = 0; i < N; i++) hist[k][i] = 0;
        for (int i = 0; i < 8; i++) sv[k][i] = 1'b0;
        ph[k] = 1'b0;
    endtask

    task automatic model_edge(input int k);
        bit flush;
        int slot;
        if (rst) begin
            clear_state(k);
            ev[k] = 1'b0;
            ed[k] = 0;
            prevb[k] = byp;
        end else begin
            flush = (byp != prevb[k]);
            prevb[k] = byp;
            if (flush || byp) clear_state(k);
            if (byp) begin
                ev[k] = vld;
                ed[k] = int'(din);
            end else begin
                slot = cyc % 8;
                ev[k] = sv[k][slot];
                if (ev[k]) ed[k] = sd[k][slot];
                sv[k][slot] = 1'b0;
                if (vld) begin
                    for (int i = N - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                    hist[k][0] = int'(din);
                    ph[k] = ~ph[k];
                    if (!ph[k]) begin
                        sv[k][(cyc + 4) % 8] = 1'b1;
                        sd[k][(cyc + 4) % 8] = ref_y(k);
                    end
                end
            end
        end
    endtask

    task automatic step(input int b, input int v, input int d);
        byp = (b != 0);
        vld = (v != 0);
        din = W'(d);
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check("valid0", longint'(ov0), longint'(ev[0]));
        check("data0", longint'(out0), longint'(ed[0]));
        check("valid1", longint'(ov1), longint'(ev[1]));
        check("data1", longint'(out1), longint'(ed[1]));
        if (ov0) begin
            got0.push_back(int'(out0));
            last0 = int'(out0);
        end
        if (ov1) last1 = int'(out1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, longint'(got0.size()), longint'(expq.size()));
        foreach (expq[i]) begin
            if (i < got0.size()) check(tag, longint'(got0[i]), longint'(expq[i]));
        end
    endtask

    task automatic impulse_even(input int amp);
        do_reset();
        got0.delete();
        step(0, 1, amp);
        repeat (11) step(0, 1, 0);
        repeat (5) step(0, 0, 0);
    endtask

    initial begin
        coef[0] = '{300, -1900, 9792};
        coef[1] = '{16384, 16384, 16384};
        rst = 1'b1; byp = 1'b0; vld = 1'b0; din = '0;
        last0 = 0; last1 = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;

        // Odd-aligned impulse
        got0.delete();
        step(0, 1, 0);
        step(0, 1, 16384);
        repeat (12) step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        expq = '{150, -950, 4896, 4896, -950, 150, 0};
        check_seq("odd_impulse");

        impulse_even(16384);
        expq = '{0, 0, 8192, 0, 0, 0};
        check_seq("even_impulse");
        impulse_even(1);
        expq = '{0, 0, 1, 0, 0, 0};
        check_seq("round_pos");
        impulse_even(-1);
        expq = '{0, 0, 0, 0, 0, 0};
        check_seq("round_neg");

        // Saturation on the 3.5x-gain instance
        do_reset();
        repeat (30) step(0, 1, 20000);
        repeat (5) step(0, 0, 0);
        check("sat_hi", longint'(last1), 32767);
        repeat (30) step(0, 1, -20000);
        repeat (5) step(0, 0, 0);
        check("sat_lo", longint'(last1), -32768);

        // DC 100 with random valid gaps
        repeat (80) step(0, int'($urandom_range(0, 1)), 100);
        repeat (6) step(0, 0, 0);
        check("dc100_gaps", longint'(last0), 100);

        // Bypass pass-through
        step(1, 1, 5);
        check("bypass_5", longint'(out0), 5);
        step(1, 1, 6);
        step(1, 1, 7);
        step(1, 0, 0);

        // Flush kills an in-flight filter output
        step(0, 0, 0);
        got0.delete();
        step(0, 1, 1000);
        step(0, 1, 2000);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (4) step(1, 0, 0);
        check("flush_kill", longint'(got0.size()), 0);
        got0.delete();
        repeat (12) step(0, 1, 100);
        repeat (6) step(0, 0, 0);
        check("flush_dc_count", longint'(got0.size()), 6);
        if (got0.size() >= 6) check("flush_dc_6th", longint'(got0[5]), 100);

        // Reset two clocks after a pair completes
        got0.delete();
        step(0, 1, 300);
        step(0, 1, 400);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        check("rst_out_data", longint'(out0), 0);
        step(0, 1, 50);
        step(0, 1, 60);
        repeat (6) step(0, 0, 0);
        check("rst_pair_count", longint'(got0.size()), 1);
        if (got0.size() >= 1) check("rst_pair_val", longint'(got0[0]), 1);

        // Random data, valids, mode toggles and occasional resets
        for (int n = 0; n < 400; n++) begin
            int b;
            b = ($urandom_range(0, 24) == 0) ? int'(!byp) : int'(byp);
            rst = ($urandom_range(0, 99) == 0);
            step(b, int'($urandom_range(0, 3) != 0), int'($signed(16'($urandom))));
        end
        rst = 1'b0;
        repeat (8) step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
